freq_counter: RTL and testbench
===============================

// Module: freq_counter
// PURPOSE
//  Gate-time frequency counter: the stage directly upstream of the 50 Hz filter.
//  - Counts rising edges of the asynchronous theremin oscillator (osc_in) over a
//    fixed window of GATE_CYCLES clk cycles.
//  - Emits one unsigned, saturated count per window on out_data/out_valid.
//  - out_data/out_valid connect straight to the filter's in_data/in_valid.
//  - The default window gives the filter its 1-in-49-clock sample strobe.
// PARAMETERS
//  GATE_CYCLES  49  window length in clk cycles (>=4); also the out_valid period
//  OUT_W        16  width of out_data; the count saturates at 2**OUT_W-1
//  SYNC_STAGES  2   synchroniser flops on osc_in (>=2)
// PORTS
//  clk        in   1      system clock; everything is on its rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  osc_in     in   1      oscillator square wave, asynchronous to clk
//  en         in   1      count enable; low = block idle and cleared
//  out_data   out  OUT_W  edge count of the last completed window
//  out_valid  out  1      one-cycle strobe; out_data is valid while it is high
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, gate_cnt=0, edge_cnt=0, sync flops=0,
//    primed=0.
//  - Edge path: SYNC_STAGES flops, then one delay flop.
//    - rise = sync_q & ~dly_q.
//    - Latency from an osc_in rising edge to its increment of edge_cnt is
//      SYNC_STAGES+1 clocks.
//  - Gate: gate_cnt counts 0..GATE_CYCLES-1 while en=1, then wraps to 0.
//  - Close cycle (gate_cnt==GATE_CYCLES-1 and en=1):
//    - out_data <= sat(edge_cnt + rise); a rise on the close cycle belongs to
//      the closing window.
//    - out_valid <= primed; edge_cnt <= 0; primed <= 1.
//  - Other cycles: edge_cnt <= sat(edge_cnt + rise); out_valid <= 0.
//  - out_data holds its value between strobes.
//  - Saturation: edge_cnt is OUT_W+1 bits internally. The emitted value is
//    clamped to 2**OUT_W-1 and never wraps.
//  - Priming: the first window after reset_n release produces no out_valid.
//    This discards the spurious edge from the sync chain leaving reset while
//    osc_in is high.
//  - en low:
//    - gate_cnt and edge_cnt clear to 0 and out_valid is 0.
//    - out_data holds; primed is unchanged.
//    - The sync chain keeps running.
//  - en re-asserted: a fresh full window starts at gate_cnt=0. Re-enabling does
//    not re-prime.
//  - en falling on the close cycle: no strobe, the window is lost.
//  - Reset mid-window: everything returns to reset values at once. No partial
//    count is ever emitted.
//  - out_valid strobes are exactly GATE_CYCLES clocks apart while en stays high.
//    There is no backpressure; the downstream stage must accept every strobe.
// CONFIGURATION
//  - FREQ_COUNTER_OVF_EN defined:
//    - Adds port ovf_clr (in, 1) and port ovf (out, 1, reset 0).
//    - ovf is a sticky flag, set on any close cycle whose emitted value was
//      clamped.
//    - ovf_clr=1 clears ovf next cycle. A set and a clear in the same cycle:
//      the set wins.
//  - FREQ_COUNTER_OVF_EN undefined: neither port exists. Saturation still
//    applies.
// STRUCTURE
//  - freq_counter_pkg:
//    - SAMPLE_W=16 and typedef logic [SAMPLE_W-1:0] sample_t, shared with the
//      filter.
//    - Default GATE_CYCLES constant, and a sat() function.
//  - Sub-module sync_edge_det (param STAGES): osc_in -> rise pulse. Flops reset
//    to 0.
//  - Gate counter, edge accumulator and output register stay in the top module.
// TESTING
//  - osc period 10 clk, GATE_CYCLES=100, en=1 -> first window silent, then
//    out_data=10 every 100 clk.
//  - osc period 10 clk, default GATE_CYCLES=49 -> out_data only ever 4 or 5;
//    the sum over 10 strobes is 49+-1.
//  - OUT_W=4, GATE_CYCLES=100, osc period 4 -> out_data=15; ovf=1 with the
//    macro; ovf_clr pulse -> ovf=0 next clk, then ovf=1 again at the next close.
//  - osc_in held high through reset, no toggles -> no out_valid ever; out_data
//    stays 0.
//  - Single osc edge arriving so the rise lands on the close cycle -> counted in
//    the closing window (out_data=1); the next window reads 0.
//  - en low for 30 clk mid-window, then high -> no strobe during the gap; the
//    next strobe comes exactly GATE_CYCLES clk after en rises, with no
//    priming loss.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and helpers for the gate-time frequency counter and its filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package freq_counter_pkg;

  // Sample width shared with the downstream 50 Hz filter.
  localparam int SAMPLE_W = 16;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Default gate window; gives the filter a 1-in-49-clock sample strobe.
  localparam int DEF_GATE_CYCLES = 49;

  // Unsigned clamp of val to max_val. Callers keep their operands well below
  // 32 bits, so the comparison never overflows.
  function automatic logic [31:0] sat(input logic [31:0] val, input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous square wave and flags its rising edges.
// Latency: rise is high STAGES clocks after the input edge is first sampled.
// Backpressure: none; one rise pulse per synchronised edge.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset; all flops clear to 0
//   async_in  in   asynchronous input
//   rise      out  one-cycle pulse per rising edge of the synchronised input
module sync_edge_det #(
  parameter int STAGES = 2   // >= 2 for metastability protection
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_counter.sv
// Gate-time frequency counter: counts osc_in rising edges per GATE_CYCLES window.
// Latency: osc_in edge reaches edge_cnt after SYNC_STAGES+1 clocks; one strobe per window.
// Backpressure: none; the downstream stage must accept every out_valid strobe.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   osc_in     in   oscillator square wave, asynchronous to clk
//   en         in   count enable; low idles and clears the window
//   out_data   out  saturated edge count of the last completed window
//   out_valid  out  one-cycle strobe marking a new out_data
//   ovf_clr    in   (FREQ_COUNTER_OVF_EN only) clears the sticky overflow flag
//   ovf        out  (FREQ_COUNTER_OVF_EN only) sticky flag: a window was clamped
//
// Build option: define FREQ_COUNTER_OVF_EN to add the ovf/ovf_clr ports.
module freq_counter
  import freq_counter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,  // >= 4
  parameter int OUT_W       = SAMPLE_W,         // <= 30
  parameter int SYNC_STAGES = 2                 // >= 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             osc_in,
  input  logic             en,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid
`ifdef FREQ_COUNTER_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam int CW = OUT_W + 1;
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  // edge_cnt carries one extra bit so a window that overshoots the output
  // range is still distinguishable from one that lands exactly on the maximum.
  localparam logic [31:0] CNT_MAX = (32'd1 << CW) - 32'd1;
  localparam logic [31:0] OUT_MAX = (32'd1 << OUT_W) - 32'd1;

  logic          rise;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_cnt;
  logic          primed;
  logic [31:0]   sum;
  logic          close;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (osc_in),
    .rise     (rise)
  );

  // A rise on the close cycle is folded into the closing window.
  assign sum   = 32'(edge_cnt) + 32'(rise);
  assign close = en && (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      primed    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!en) begin
      // Idle: window discarded, out_data and primed kept.
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (close) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      out_data  <= OUT_W'(sat(sum, OUT_MAX));
      // The first window after reset may hold a spurious edge from the sync
      // chain leaving reset with osc_in high, so it is never emitted.
      out_valid <= primed;
      primed    <= 1'b1;
    end else begin
      gate_cnt  <= gate_cnt + 1'b1;
      edge_cnt  <= CW'(sat(sum, CNT_MAX));
      out_valid <= 1'b0;
    end
  end

`ifdef FREQ_COUNTER_OVF_EN
  logic clamped;
  assign clamped = sum > OUT_MAX;

  // Set has priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (close && clamped) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: four instances with different windows and widths.
// Expected strobe values are queued when stimulus is set up and popped by a
// monitor that samples outputs 1 time unit after each rising clock edge.
module tb_freq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic rst_d_n = 1'b0;
  logic en_abc  = 1'b0;
  logic en_d    = 1'b0;
  logic osc_a   = 1'b0;
  logic osc_c   = 1'b0;
  logic osc_d   = 1'b0;
  logic d_mode  = 1'b0;   // 0: osc_d follows d_lvl, 1: osc_d toggles, period 4
  logic d_lvl   = 1'b0;

  logic [15:0] a_dat, b_dat, d_dat;
  logic [3:0]  c_dat;
  logic        a_vld, b_vld, c_vld, d_vld;

`ifdef FREQ_COUNTER_OVF_EN
  logic tie0 = 1'b0;
  logic ovf_clr_c = 1'b0;
  logic ovf_a, ovf_b, ovf_c, ovf_d;
`endif

  freq_counter #(.GATE_CYCLES(100), .OUT_W(16), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset_n(rst_n), .osc_in(osc_a), .en(en_abc),
    .out_data(a_dat), .out_valid(a_vld)
`ifdef FREQ_COUNTER_OVF_EN
    , .ovf_clr(tie0), .ovf(ovf_a)
`endif
  );

  freq_counter u_b (
    .clk(clk), .reset_n(rst_n), .osc_in(osc_a), .en(en_abc),
    .out_data(b_dat), .out_valid(b_vld)
`ifdef FREQ_COUNTER_OVF_EN
    , .ovf_clr(tie0), .ovf(ovf_b)
`endif
  );

  freq_counter #(.GATE_CYCLES(100), .OUT_W(4)) u_c (
    .clk(clk), .reset_n(rst_n), .osc_in(osc_c), .en(en_abc),
    .out_data(c_dat), .out_valid(c_vld)
`ifdef FREQ_COUNTER_OVF_EN
    , .ovf_clr(ovf_clr_c), .ovf(ovf_c)
`endif
  );

  freq_counter #(.GATE_CYCLES(20)) u_d (
    .clk(clk), .reset_n(rst_d_n), .osc_in(osc_d), .en(en_d),
    .out_data(d_dat), .out_valid(d_vld)
`ifdef FREQ_COUNTER_OVF_EN
    , .ovf_clr(tie0), .ovf(ovf_d)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Oscillators change 1 unit after a falling edge, so a level written by the
  // main sequence on a falling edge is first sampled on the next rising edge.
  initial forever begin
    repeat (5) @(negedge clk);
    #1 osc_a = ~osc_a;
  end

  initial forever begin
    repeat (2) @(negedge clk);
    #1 osc_c = ~osc_c;
  end

  int d_ph = 0;
  initial forever begin
    @(negedge clk);
    #1;
    if (d_mode) begin
      d_ph++;
      if (d_ph >= 2) begin
        osc_d = ~osc_d;
        d_ph  = 0;
      end
    end else begin
      osc_d = d_lvl;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int q_a[$];
  int q_c[$];
  int q_d[$];
  int a_n = 0, a_prev = 0;
  int b_n = 0, b_sum = 0;
  int d_n = 0, d_last = 0;

  // Scoreboard side: every strobe must match the head of its queue.
  initial forever begin
    @(posedge clk);
    #1;
    if (a_vld) begin
      if (q_a.size() == 0) chk("a_unexpected_strobe", 1, 0);
      else chk("a_data", a_dat, q_a.pop_front());
      if (a_n > 0) chk("a_period", cyc - a_prev, 100);
      a_prev = cyc;
      a_n++;
    end
    if (b_vld) begin
      chk("b_value_4_or_5", (b_dat == 16'd4 || b_dat == 16'd5), 1);
      if (b_n < 10) b_sum += int'(b_dat);
      b_n++;
    end
    if (c_vld) begin
      if (q_c.size() == 0) chk("c_unexpected_strobe", 1, 0);
      else chk("c_data", c_dat, q_c.pop_front());
    end
    if (d_vld) begin
      if (q_d.size() == 0) chk("d_unexpected_strobe", 1, 0);
      else chk("d_data", d_dat, q_d.pop_front());
      d_last = cyc;
      d_n++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    int en_cyc;

    // ---------------- phase 1: instances a, b, c ----------------
    d_lvl  = 1'b1;     // osc_d held high through u_d's first reset
    en_abc = 1'b1;
    step(3);
    chk("a_reset_valid", a_vld, 0);
    chk("a_reset_data", a_dat, 0);
    chk("c_reset_data", c_dat, 0);
    chk("b_reset_valid", b_vld, 0);
`ifdef FREQ_COUNTER_OVF_EN
    chk("c_reset_ovf", ovf_c, 0);
`endif
    // First window silent, then 10 edges per 100-clock window (strobes at 200..600).
    for (int i = 0; i < 5; i++) q_a.push_back(10);
    // 25 edges per window into a 4-bit output clamps to 15.
    for (int i = 0; i < 5; i++) q_c.push_back(15);
    rst_n = 1'b1;      // rel 0

`ifdef FREQ_COUNTER_OVF_EN
    step(250);         // rel 250
    chk("c_ovf_set", ovf_c, 1);
    ovf_clr_c = 1'b1;
    step(1);           // rel 251
    chk("c_ovf_cleared", ovf_c, 0);
    ovf_clr_c = 1'b0;
    step(49);          // rel 300: close at posedge 300 sets it again
    chk("c_ovf_reset_again", ovf_c, 1);
    step(350);         // rel 650
`else
    step(650);         // rel 650
`endif
    en_abc = 1'b0;     // next closes at 686/700 must not strobe
    step(60);          // rel 710
    chk("a_strobes_done", q_a.size(), 0);
    chk("c_strobes_done", q_c.size(), 0);
    chk("a_data_holds", a_dat, 10);
    chk("c_data_holds", c_dat, 15);
    chk("b_ten_strobes", (b_n >= 10), 1);
    chk("b_sum_49pm1", (b_sum >= 48 && b_sum <= 50), 1);

    // ---------------- phase 2: instance d, window 20 ----------------
    // Test 1: osc held high through reset; priming window swallows the
    // spurious edge and later windows read 0.
    en_d = 1'b1;
    q_d.push_back(0);
    q_d.push_back(0);
    step(1);
    rst_d_n = 1'b1;    // rel 0
    step(70);          // strobes at 40 and 60
    chk("d_high_data_zero", d_dat, 0);
    chk("d_high_strobes_done", q_d.size(), 0);
    rst_d_n = 1'b0;

    // Test 2: single edge whose rise lands on the close cycle (posedge 40).
    d_lvl = 1'b0;
    step(3);
    q_d.push_back(1);
    q_d.push_back(0);
    rst_d_n = 1'b1;    // rel 0
    step(37);
    d_lvl = 1'b1;      // sampled from posedge 38, rise on posedge 40
    step(28);          // rel 65
    chk("d_close_edge_done", q_d.size(), 0);
    rst_d_n = 1'b0;

    // Test 3: toggling osc (5 edges per window), en gap mid-window.
    d_mode = 1'b1;
    step(3);
    q_d.push_back(5);  // window 2, strobe at 40
    rst_d_n = 1'b1;    // rel 0
    step(50);          // rel 50, mid window 3
    en_d = 1'b0;
    n0 = d_n;
    step(30);          // rel 80
    chk("d_gap_no_strobe", d_n, n0);
    q_d.push_back(5);
    en_d   = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 25 && d_n == n0; i++) step(1);
    chk("d_reen_strobe_seen", d_n, n0 + 1);
    chk("d_reen_delay", d_last - en_cyc, 20);
    step(8);           // mid window
    rst_d_n = 1'b0;
    #1;
    chk("d_midreset_data", d_dat, 0);
    chk("d_midreset_valid", d_vld, 0);
    step(25);
    chk("d_no_partial_strobe", d_vld, 0);
    chk("d_all_strobes_done", q_d.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
